alarm_controlnstance: RTL and testbench

ALARM_CONTROLNSTANCE -- requirements
Module: alarm_controlnstance

---
 rtl/alarm_controlnstance.sv | 84 ++++++++
 tb/tb_alarm_controlnstance.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_controlnstance.sv
// Alarm-setting controller: debounces SW_F1/SW_F2 through 2-flop synchronizers plus an edge-history flop.
// SW_F1 walks the field select; SW_F2 emits one registered increment/toggle pulse for the selected field.
module alarm_controlnstance (
  input  logic CLK,
  input  logic RST,
  input  logic SW_F1,
  input  logic SW_F2,
  output logic ALM_HOUR,
  output logic ALM_MIN,
  output logic ALM_ONOFF
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_HOUR  = 2'd1,
    SET_MIN   = 2'd2,
    SET_ONOFF = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // bit 0: first sync stage, bit 1: second sync stage, bit 2: history
  logic [2:0] f1_sync;
  logic [2:0] f2_sync;

  logic press_f1;
  logic press_f2;
  logic hour_nxt;
  logic min_nxt;
  logic onoff_nxt;

  assign press_f1 = f1_sync[1] & ~f1_sync[2];
  assign press_f2 = f2_sync[1] & ~f2_sync[2];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      f1_sync <= 3'b000;
      f2_sync <= 3'b000;
    end else begin
      f1_sync <= {f1_sync[1:0], SW_F1};
      f2_sync <= {f2_sync[1:0], SW_F2};
    end
  end

  // The pulse is chosen from the current state even when SW_F1 advances it in the same cycle.
  always_comb begin
    state_nxt = state;
    hour_nxt  = 1'b0;
    min_nxt   = 1'b0;
    onoff_nxt = 1'b0;
    if (press_f2) begin
      case (state)
        SET_HOUR:  hour_nxt  = 1'b1;
        SET_MIN:   min_nxt   = 1'b1;
        SET_ONOFF: onoff_nxt = 1'b1;
        default:   ;
      endcase
    end
    if (press_f1) begin
      case (state)
        IDLE:      state_nxt = SET_HOUR;
        SET_HOUR:  state_nxt = SET_MIN;
        SET_MIN:   state_nxt = SET_ONOFF;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      ALM_HOUR  <= 1'b0;
      ALM_MIN   <= 1'b0;
      ALM_ONOFF <= 1'b0;
    end else begin
      state     <= state_nxt;
      ALM_HOUR  <= hour_nxt;
      ALM_MIN   <= min_nxt;
      ALM_ONOFF <= onoff_nxt;
    end
  end

endmodule

// File: tb/tb_alarm_controlnstance.sv
// Scoreboard bench: stimulus pushes expected {cycle, output} entries, a negedge monitor pops and compares.
module tb_alarm_controlnstance;

  logic CLK;
  logic RST;
  logic SW_F1;
  logic SW_F2;
  logic ALM_HOUR;
  logic ALM_MIN;
  logic ALM_ONOFF;

  alarm_controlnstance dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW_F1     (SW_F1),
    .SW_F2     (SW_F2),
    .ALM_HOUR  (ALM_HOUR),
    .ALM_MIN   (ALM_MIN),
    .ALM_ONOFF (ALM_ONOFF)
  );

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] HOUR  = 3'b100;
  localparam logic [2:0] MIN   = 3'b010;
  localparam logic [2:0] ONOFF = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [2:0] outs;
  assign outs = {ALM_HOUR, ALM_MIN, ALM_ONOFF};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: any output activity must match the head of the queue in cycle and field.
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: no pulse seen, required out=%b at cycle %0d (now %0d)",
               exp_q[0].out, exp_q[0].cyc, cyc);
      void'(exp_q.pop_front());
    end
    if (outs != NONE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: out=%b at cycle %0d, required none", outs, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.out != outs) begin
          errors++;
          $display("FAIL pulse: got out=%b at cycle %0d, required out=%b at cycle %0d",
                   outs, cyc, e.out, e.cyc);
        end
      end
    end
  end

  task automatic check_reset_state(input string name);
    checks++;
    if (outs != NONE || dut.state != 2'd0) begin
      errors++;
      $display("FAIL %s: out=%b state=%0d, required out=000 state=0", name, outs, dut.state);
    end
  endtask

  // Press buttons at a negedge for 'hold' cycles; a press sampled at edge N pulses at N+2.
  task automatic press(input logic f1, input logic f2, input int hold, input logic [2:0] exp_out);
    exp_t e;
    @(negedge CLK);
    SW_F1 = f1;
    SW_F2 = f2;
    if (exp_out != NONE) begin
      e.cyc = cyc + 3;
      e.out = exp_out;
      exp_q.push_back(e);
    end
    repeat (hold) @(negedge CLK);
    SW_F1 = 1'b0;
    SW_F2 = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    exp_t e;
    RST   = 1'b0;
    SW_F1 = 1'b0;
    SW_F2 = 1'b0;

    // Reset with buttons toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      SW_F1 = i[0];
      SW_F2 = ~i[0];
      check_reset_state("reset_hold");
    end
    @(negedge CLK);
    SW_F1 = 1'b0;
    SW_F2 = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    check_reset_state("after_release");
    press(1'b0, 1'b1, 1, NONE);

    // Hour adjust: three separate presses
    press(1'b1, 1'b0, 1, NONE);
    press(1'b0, 1'b1, 1, HOUR);
    press(1'b0, 1'b1, 2, HOUR);
    press(1'b0, 1'b1, 1, HOUR);

    // Field walk
    press(1'b1, 1'b0, 1, NONE);
    press(1'b0, 1'b1, 1, MIN);
    press(1'b1, 1'b0, 1, NONE);
    press(1'b0, 1'b1, 1, ONOFF);
    press(1'b1, 1'b0, 1, NONE);
    press(1'b0, 1'b1, 1, NONE);

    // Held F2 in SET_MIN
    press(1'b1, 1'b0, 1, NONE);
    press(1'b1, 1'b0, 3, NONE);
    press(1'b0, 1'b1, 3, MIN);

    // Simultaneous F1+F2 in SET_MIN: MIN pulse, then SET_ONOFF
    press(1'b1, 1'b1, 1, MIN);
    press(1'b0, 1'b1, 1, ONOFF);

    // Back-to-back presses separated by a single low sample
    @(negedge CLK);
    SW_F2 = 1'b1;
    e.cyc = cyc + 3; e.out = ONOFF; exp_q.push_back(e);
    @(negedge CLK);
    SW_F2 = 1'b0;
    @(negedge CLK);
    SW_F2 = 1'b1;
    e.cyc = cyc + 3; e.out = ONOFF; exp_q.push_back(e);
    @(negedge CLK);
    SW_F2 = 1'b0;
    repeat (5) @(negedge CLK);

    // Reset mid-operation with an F2 press in flight in SET_ONOFF
    @(negedge CLK);
    SW_F2 = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check_reset_state("reset_midop");
    SW_F2 = 1'b0;
    @(negedge CLK);
    check_reset_state("reset_midop_hold");
    RST = 1'b1;
    repeat (5) @(negedge CLK);
    check_reset_state("after_midop");

    // Button held across reset release counts as one press
    @(negedge CLK);
    RST   = 1'b0;
    SW_F1 = 1'b1;
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) @(negedge CLK);
    SW_F1 = 1'b0;
    repeat (3) @(negedge CLK);
    press(1'b0, 1'b1, 1, HOUR);

    repeat (10) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expected pulses not seen, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
